// File: rtl/sdf_twiddle_ctrl.sv
// sdf_twiddle_ctrl: slot sequencer and twiddle source for one radix-2 SDF FFT stage
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid_i     a sample is presented this cycle
//   flush_i        drain request, honoured only when idle at slot 0 with a full delay line
//   inv_i          inverse transform (conjugate twiddles), taken at frame boundaries
//   state_o        0 FILL, 1 BFLY, 2 TWID for the slot of the current sample
//   w_r_o, w_i_o   twiddle, signed with 8 fractional bits
//   k_idx_o        twiddle index of the current slot (0 outside TWID)
//   out_valid_o    stage output valid this cycle
//   busy_o         delay line holds data or a drain is running
//   ovf_o          sticky: a sample arrived while draining and was dropped
module sdf_twiddle_ctrl #(
  parameter int DEPTH = 8,
  parameter int TW_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid_i,
  input  logic                     flush_i,
  input  logic                     inv_i,
  output logic [1:0]               state_o,
  output logic signed [TW_W-1:0]   w_r_o,
  output logic signed [TW_W-1:0]   w_i_o,
  output logic [$clog2(DEPTH):0]   k_idx_o,
  output logic                     out_valid_o,
  output logic                     busy_o,
  output logic                     ovf_o
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST = PW'(2 * DEPTH - 1);
  localparam logic [8:0] QT [17] = '{9'd256, 9'd255, 9'd251, 9'd245, 9'd237, 9'd226, 9'd213, 9'd198,
                                     9'd181, 9'd162, 9'd142, 9'd121, 9'd98, 9'd74, 9'd50, 9'd25, 9'd0};
  typedef enum logic [1:0] {FILL = 2'd0, BFLY = 2'd1, TWID = 2'd2} slot_e;
  logic [PW-1:0] pos_q, pos_d;
  logic filled_q, filled_d, draining_q, draining_d, inv_q, inv_d, ovf_q, ovf_d;
  logic advance, half_last, drain_end, hi;
  slot_e slot;
  logic [PW-1:0] k;
  logic [4:0] a, b, cm, sm;
  logic signed [9:0] cq, sq, cos_v, w_i_v;
  always_comb begin
    advance = in_valid_i | draining_q;
    half_last = (pos_q == HALF_LAST);
    drain_end = draining_q & half_last;
    // 2*DEPTH is a power of two, so the position counter wraps on its own
    pos_d = drain_end ? '0 : pos_q + PW'(advance);
    filled_d = ~drain_end & (filled_q | (advance & half_last));
    draining_d = draining_q ? ~half_last : (flush_i & ~in_valid_i & filled_q & (pos_q == '0));
    inv_d = (((pos_q == '0) & ~advance) | (advance & (pos_q == LAST))) ? inv_i : inv_q;
    ovf_d = ovf_q | (in_valid_i & draining_q);
    slot = pos_q[PW-1] ? BFLY : filled_q ? TWID : FILL;
    k = (slot == TWID) ? pos_q : '0;
    // angle in 64ths of a turn; k < DEPTH keeps it below 32
    a = 5'(32'(k) * (32 / DEPTH));
    hi = (a > 5'd16);
    b = a - 5'd16;
    cm = hi ? 5'd16 - b : a;
    sm = hi ? b : 5'd16 - a;
    cq = {1'b0, QT[cm]};
    sq = {1'b0, QT[sm]};
    cos_v = hi ? -cq : cq;
    w_i_v = inv_q ? sq : -sq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      filled_q <= 1'b0;
      draining_q <= 1'b0;
      inv_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      filled_q <= filled_d;
      draining_q <= draining_d;
      inv_q <= inv_d;
      ovf_q <= ovf_d;
    end
  end
  assign state_o = slot;
  assign k_idx_o = k;
  assign w_r_o = TW_W'(cos_v);
  assign w_i_o = TW_W'(w_i_v);
  assign out_valid_o = advance & (slot != FILL);
  assign busy_o = filled_q | draining_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_sdf_twiddle_ctrl.sv
// tb_sdf_twiddle_ctrl: directed checks of the SDF sequencer at DEPTH 8, 1 and 32
module tb_sdf_twiddle_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n_a = 1'b0, iv_a = 1'b0, fl_a = 1'b0, inv_a = 1'b0;
  logic rst_n_b = 1'b0, iv_b = 1'b0, fl_b = 1'b0, inv_b = 1'b0;
  logic [1:0] st_a, st_c, st_d;
  logic signed [23:0] wr_a, wi_a, wr_c, wi_c, wr_d, wi_d;
  logic [3:0] k_a;
  logic [5:0] k_c;
  logic [0:0] k_d;
  logic ov_a, busy_a, ovf_a, ov_c, busy_c, ovf_c, ov_d, busy_d, ovf_d;
  int n_tests = 0, n_fail = 0;
  int wr_t[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  int sn_t[8] = '{0, 98, 181, 237, 256, 237, 181, 98};
  sdf_twiddle_ctrl #(.DEPTH(8), .TW_W(24)) dut8 (
    .clk(clk), .rst_n(rst_n_a), .in_valid_i(iv_a), .flush_i(fl_a), .inv_i(inv_a),
    .state_o(st_a), .w_r_o(wr_a), .w_i_o(wi_a), .k_idx_o(k_a),
    .out_valid_o(ov_a), .busy_o(busy_a), .ovf_o(ovf_a));
  sdf_twiddle_ctrl #(.DEPTH(32), .TW_W(24)) dut32 (
    .clk(clk), .rst_n(rst_n_b), .in_valid_i(iv_b), .flush_i(fl_b), .inv_i(inv_b),
    .state_o(st_c), .w_r_o(wr_c), .w_i_o(wi_c), .k_idx_o(k_c),
    .out_valid_o(ov_c), .busy_o(busy_c), .ovf_o(ovf_c));
  sdf_twiddle_ctrl #(.DEPTH(1), .TW_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n_b), .in_valid_i(iv_b), .flush_i(fl_b), .inv_i(inv_b),
    .state_o(st_d), .w_r_o(wr_d), .w_i_o(wi_d), .k_idx_o(k_d),
    .out_valid_o(ov_d), .busy_o(busy_d), .ovf_o(ovf_d));
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc_a(input logic v, input logic f);
    @(negedge clk);
    iv_a = v;
    fl_a = f;
    #1;
  endtask
  task automatic cyc_b(input logic v, input logic f);
    @(negedge clk);
    iv_b = v;
    fl_b = f;
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", st_a, 0);
    chk("rst_k", k_a, 0);
    chk("rst_wr", wr_a, 256);
    chk("rst_wi", wi_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    rst_n_a = 1'b1;
    for (int p = 0; p < 16; p++) begin
      cyc_a(1'b1, 1'b0);
      chk("f1_state", st_a, p < 8 ? 0 : 1);
      chk("f1_ov", ov_a, p < 8 ? 0 : 1);
      chk("f1_wr", wr_a, 256);
      chk("f1_wi", wi_a, 0);
    end
    for (int p = 0; p < 16; p++) begin
      if (p == 5) inv_a = 1'b1;
      if (p == 10) begin
        for (int s = 0; s < 3; s++) begin
          cyc_a(1'b0, 1'b1);
          chk("stall_state", st_a, 1);
          chk("stall_ov", ov_a, 0);
          chk("stall_wr", wr_a, 256);
          chk("stall_busy", busy_a, 1);
        end
      end
      cyc_a(1'b1, 1'b0);
      chk("f2_state", st_a, p < 8 ? 2 : 1);
      chk("f2_k", k_a, p < 8 ? p : 0);
      chk("f2_ov", ov_a, 1);
      chk("f2_wr", wr_a, p < 8 ? wr_t[p] : 256);
      chk("f2_wi", wi_a, p < 8 ? -sn_t[p] : 0);
      if (p == 1) chk("f2_wi_enc", {8'h00, wi_a}, 32'h00FFFF9E);
    end
    for (int p = 0; p < 16; p++) begin
      cyc_a(1'b1, p == 0);
      chk("f3_state", st_a, p < 8 ? 2 : 1);
      chk("f3_k", k_a, p < 8 ? p : 0);
      chk("f3_ov", ov_a, 1);
      chk("f3_wr", wr_a, p < 8 ? wr_t[p] : 256);
      chk("f3_wi", wi_a, p < 8 ? sn_t[p] : 0);
      if (p == 1) chk("f3_wi_enc", {8'h00, wi_a}, 32'h00000062);
    end
    inv_a = 1'b0;
    cyc_a(1'b0, 1'b1);
    chk("fl_state", st_a, 2);
    chk("fl_ov", ov_a, 0);
    chk("fl_busy", busy_a, 1);
    for (int i = 0; i < 8; i++) begin
      cyc_a(i == 3, 1'b0);
      chk("dr_state", st_a, 2);
      chk("dr_k", k_a, i);
      chk("dr_ov", ov_a, 1);
      chk("dr_busy", busy_a, 1);
      chk("dr_wr", wr_a, wr_t[i]);
      chk("dr_wi", wi_a, -sn_t[i]);
      chk("dr_ovf", ovf_a, i > 3 ? 1 : 0);
    end
    cyc_a(1'b0, 1'b0);
    chk("post_state", st_a, 0);
    chk("post_busy", busy_a, 0);
    chk("post_ov", ov_a, 0);
    chk("post_k", k_a, 0);
    chk("post_ovf", ovf_a, 1);
    cyc_a(1'b1, 1'b0);
    chk("post_fill_state", st_a, 0);
    chk("post_fill_ov", ov_a, 0);
    cyc_b(1'b0, 1'b0);
    rst_n_b = 1'b1;
    for (int j = 0; j < 128; j++) begin
      cyc_b(1'b1, 1'b0);
      chk("d32_state", st_c, j < 32 ? 0 : j < 64 ? 1 : j < 96 ? 2 : 1);
      chk("d32_k", k_c, (j >= 64 && j < 96) ? j - 64 : 0);
      chk("d32_ov", ov_c, j >= 32 ? 1 : 0);
      if (j == 65) begin chk("d32_k1_wr", wr_c, 255); chk("d32_k1_wi", wi_c, -25); end
      if (j == 72) begin chk("d32_k8_wr", wr_c, 181); chk("d32_k8_wi", wi_c, -181); end
      if (j == 80) begin chk("d32_k16_wr", wr_c, 0); chk("d32_k16_wi", wi_c, -256); end
      if (j == 95) begin chk("d32_k31_wr", wr_c, -255); chk("d32_k31_wi", wi_c, -25); end
      chk("d1_state", st_d, j == 0 ? 0 : (j % 2 == 1) ? 1 : 2);
      chk("d1_k", k_d, 0);
      chk("d1_wr", wr_d, 256);
      chk("d1_wi", wi_d, 0);
      chk("d1_ov", ov_d, j > 0 ? 1 : 0);
      chk("d1_busy", busy_d, j > 0 ? 1 : 0);
    end
    cyc_b(1'b0, 1'b1);
    chk("d32_fl_state", st_c, 2);
    chk("d32_fl_ov", ov_c, 0);
    for (int i = 0; i < 5; i++) begin
      cyc_b(1'b0, 1'b0);
      chk("d32_dr_state", st_c, 2);
      chk("d32_dr_k", k_c, i);
      chk("d32_dr_ov", ov_c, 1);
      chk("d32_dr_busy", busy_c, 1);
      chk("d1_dr_k", k_d, 0);
      chk("d1_dr_wr", wr_d, 256);
    end
    rst_n_b = 1'b0;
    #1;
    chk("d32_ar_state", st_c, 0);
    chk("d32_ar_k", k_c, 0);
    chk("d32_ar_wr", wr_c, 256);
    chk("d32_ar_wi", wi_c, 0);
    chk("d32_ar_ov", ov_c, 0);
    chk("d32_ar_busy", busy_c, 0);
    chk("d32_ar_ovf", ovf_c, 0);
    chk("d1_ar_ovf", ovf_d, 0);
    cyc_b(1'b0, 1'b0);
    rst_n_b = 1'b1;
    cyc_b(1'b1, 1'b0);
    chk("d32_rs_state", st_c, 0);
    chk("d32_rs_ov", ov_c, 0);
    cyc_b(1'b1, 1'b0);
    chk("d32_rs_k", k_c, 0);
    chk("d32_rs_busy", busy_c, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdf_twiddle_ctrl.md
Name: sdf_twiddle_ctrl

Overview:
- Parametrised sequencer and twiddle source for one radix-2 single-path delay-feedback (SDF) FFT stage with delay depth DEPTH.
- Tracks the sample position within each 2*DEPTH-sample period and tells the butterfly datapath whether to fill, butterfly or twiddle-multiply.
- Supplies W = exp(-j*2*pi*k/(2*DEPTH)) in signed Q(TW_W-8).8, or its conjugate in inverse mode.
- Adds input-valid stalling, an end-of-stream drain, and a sticky overrun flag.

Parameters:
DEPTH, 8, stage delay length; power of 2, 1..32 (local FFT size 2*DEPTH <= 64)
TW_W, 24, twiddle output width in bits, signed two's complement; 8 fractional bits fixed; >= 10

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  a sample is presented this cycle
flush  in  1  request drain of the last half-period (see Behaviour)
inv  in  1  1 = inverse transform (conjugate twiddles); latched at frame boundary
state  out  2  0 = FILL, 1 = BFLY, 2 = TWID for the current slot
w_r  out  TW_W  twiddle real part
w_i  out  TW_W  twiddle imaginary part
k_idx  out  log2(DEPTH)+1 (min 1)  twiddle index k for the current slot
out_valid  out  1  stage output valid this cycle
busy  out  1  filled or draining
ovf  out  1  sticky: in_valid asserted while draining

Behaviour:
- Registers: pos (0..2*DEPTH-1), filled, draining, inv_q, ovf.
- Reset: pos=0, filled=0, draining=0, inv_q=0, ovf=0.
- Reset outputs: state=0, k_idx=0, w_r=256, w_i=0, out_valid=0, busy=0, ovf=0.
- Output timing: state, k_idx, w_r and w_i depend on registers only and describe the slot the current cycle's sample occupies. No combinational path from in_valid to these outputs.
- advance = (in_valid & ~draining) | draining. On advance, pos <= pos+1, wrapping from 2*DEPTH-1 to 0. Without advance, all state holds (stall).
- state decode:
  - pos >= DEPTH -> BFLY (1).
  - pos < DEPTH and filled=0 -> FILL (0).
  - pos < DEPTH and filled=1 -> TWID (2).
  - Code 3 is never produced.
- filled:
  - Set when advance occurs at pos=DEPTH-1 with filled=0.
  - Cleared when draining ends.
- k_idx:
  - pos when state=TWID; 0 otherwise.
  - In BFLY and FILL, w_r=256 and w_i=0 (unity).
- Twiddle values:
  - a = k_idx * (64/(2*DEPTH)), giving the angle in 64ths of a turn, range 0..31.
  - Quarter table Q[m] = round-half-away(256*cos(2*pi*m/64)), m = 0..16. Q[0]=256, Q[4]=237, Q[8]=181, Q[12]=98, Q[16]=0.
  - a <= 16: cos = Q[a], sin = Q[16-a].
  - a > 16, with b = a-16: cos = -Q[16-b], sin = Q[b].
  - w_r = cos. w_i = -sin when inv_q=0, +sin when inv_q=1. All values sign-extended to TW_W.
- inv_q <= inv on any cycle with pos=0 and no advance in progress, and on advance out of pos=2*DEPTH-1. A mid-frame change of inv has no effect until the next frame.
- out_valid = advance & (state != FILL).
- busy = filled | draining.
- Drain:
  - Trigger: flush=1, pos=0, filled=1, draining=0 and in_valid=0 all in the same cycle. Then draining <= 1.
  - flush under any other condition is ignored (not remembered).
  - While draining: advance each cycle for DEPTH cycles in TWID (pos 0..DEPTH-1) with out_valid=1.
  - On advance at pos=DEPTH-1: draining <= 0, filled <= 0, pos <= 0. The block is then in FILL, idle.
- in_valid while draining: the sample is dropped and ovf <= 1. ovf clears only on reset.
- flush and in_valid high together at pos=0: the trigger is not met, so the sample is accepted normally.
- Reset mid-frame or mid-drain: all registers return to reset values immediately (asynchronous). The next sample is treated as FILL slot 0.

Test Plan:
- DEPTH=8, reset, then 16 continuous in_valid:
  - state = 0 for 8 cycles, then 1 for 8 cycles.
  - out_valid = 0 for the first 8 cycles, 1 for the next 8.
  - w_r=256, w_i=0 throughout.
- DEPTH=8, continue 8 more samples (TWID):
  - k=0..7 gives (w_r, w_i) = (256,0), (237,-98), (181,-181), (98,-237), (0,-256), (-98,-237), (-181,-181), (-237,-98).
  - TW_W=24 encoding: k=1 gives w_i = 0xFFFF9E.
- Same run with inv=1 applied at pos=5: no change in the current frame. Next frame, k=1 gives w_i=+98 (0x000062); w_r is unchanged.
- Stall: deassert in_valid for 3 cycles at pos=10. pos, state and twiddle hold, out_valid=0, and the sequence resumes at pos=10 without skipping.
- Drain: after 32 samples (pos=0, filled=1), pulse flush with in_valid=0:
  - 8 cycles of TWID with out_valid=1 and k=0..7.
  - Then state=0, busy=0.
  - in_valid=1 during the drain sets ovf=1 and does not disturb the drain count.
- DEPTH=1 and DEPTH=32 sweep:
  - DEPTH=1: k always 0, twiddle (256,0).
  - DEPTH=32: k=16 gives (0,-256); k=31 gives (-Q[1], -Q[15]) = (-255,-25). Reset asserted mid-drain returns all outputs to reset values.
